// File: rtl/saturn_bus_sequencer.sv
// Saturn nibble-bus sequencer: program FIFO played onto a 4-phase bus, plus counted read bursts.
// Optional protocol checker enabled by defining SATURN_BUS_SEQ_CHECK_EN.
module saturn_bus_sequencer #(
  parameter int PROG_AW  = 5,
  parameter int NIB_W    = 4,
  parameter int RD_CNT_W = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clk_en,
  input  logic [3:0]          i_phases,
  input  logic                i_prog_wr,
  input  logic [NIB_W:0]      i_prog_data,
  output logic                o_prog_full,
  output logic [PROG_AW:0]    o_prog_level,
  input  logic                i_rd_start,
  input  logic [RD_CNT_W-1:0] i_rd_count,
  output logic                o_rd_valid,
  output logic [NIB_W-1:0]    o_rd_nibble,
  output logic                o_bus_clk_en,
  output logic                o_bus_is_data,
  output logic [NIB_W-1:0]    o_bus_nibble_out,
  input  logic [NIB_W-1:0]    i_bus_nibble_in,
  output logic                o_busy,
  output logic                o_error
);
  localparam int DEPTH = 2**PROG_AW;
  localparam logic [PROG_AW:0] FULL_LVL = (PROG_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state, state_nxt;
  logic [NIB_W:0]        mem [DEPTH];
  logic [PROG_AW-1:0]    wr_ptr, rd_ptr;
  logic [PROG_AW:0]      level;
  logic [RD_CNT_W-1:0]   rd_cnt;
  logic                  push, pop, rd_sample;
  logic                  ph_drive, ph_sample, ph_settle;
  logic [NIB_W:0]        head;

  assign ph_drive     = (i_phases == 4'b0001);
  assign ph_sample    = (i_phases == 4'b0010);
  assign ph_settle    = (i_phases == 4'b0100);
  assign o_prog_full  = (level == FULL_LVL);
  assign o_prog_level = level;
  assign head         = mem[rd_ptr];

  // Full is judged on the pre-pop level, so a push while full is lost even if a pop coincides.
  always_comb begin
    push      = i_clk_en && i_prog_wr && !o_prog_full;
    pop       = 1'b0;
    rd_sample = 1'b0;
    state_nxt = state;
    if (i_clk_en) begin
      if (ph_drive) begin
        if (level != '0) begin
          pop       = 1'b1;
          state_nxt = WRITE;
        end else if (rd_cnt != '0) begin
          state_nxt = READ;
        end else begin
          state_nxt = IDLE;
        end
      end else if (ph_sample) begin
        rd_sample = (state == READ);
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_prog_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      rd_cnt           <= '0;
      o_rd_valid       <= 1'b0;
      o_rd_nibble      <= '0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
      o_busy           <= 1'b0;
    end else begin
      // The read strobe is a true one-cycle pulse, even if the clock enable drops right after it.
      o_rd_valid <= 1'b0;
      if (i_clk_en) begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + {{PROG_AW{1'b0}}, push} - {{PROG_AW{1'b0}}, pop};
        if (ph_drive) begin
          o_bus_clk_en <= pop || (rd_cnt != '0);
          if (pop) begin
            o_bus_nibble_out <= head[NIB_W-1:0];
            o_bus_is_data    <= !head[NIB_W];
          end
        end
        if (ph_sample) o_bus_clk_en <= 1'b0;
        if (rd_sample) begin
          o_rd_nibble <= i_bus_nibble_in;
          o_rd_valid  <= 1'b1;
        end
        // A fresh load overrides the decrement; a burst cancelled mid-cycle must not underflow.
        if (i_rd_start)                      rd_cnt <= i_rd_count;
        else if (rd_sample && rd_cnt != '0)  rd_cnt <= rd_cnt - 1'b1;
        if (ph_settle) o_busy <= (level != '0) || (rd_cnt != '0) || (state != IDLE);
      end
    end
  end

`ifdef SATURN_BUS_SEQ_CHECK_EN
  logic error_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) error_q <= 1'b0;
    else if (i_clk_en && ((i_prog_wr && o_prog_full) || !$onehot(i_phases) ||
                          (i_rd_start && state == READ)))
      error_q <= 1'b1;
  end
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif
endmodule

// File: doc/saturn_bus_sequencer.md
Name: saturn_bus_sequencer

Overview:
Parametrised next-generation Saturn bus controller. Holds an internal program FIFO of command/data nibbles pushed by the control unit and plays them onto the 4-phase nibble bus, one per bus cycle. Runs counted multi-nibble read bursts when no writes are pending, and reports busy, level and error status to the control unit and debugger.

Parameters:
PROG_AW, 5, program FIFO address width; depth = 2**PROG_AW entries.
NIB_W, 4, bus nibble width in bits.
RD_CNT_W, 5, width of the read-burst nibble counter; max burst = 2**RD_CNT_W-1.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_clk_en  in  1  global clock enable; when 0, all state frozen except reset
i_phases  in  4  one-hot bus phase: 0001 drive, 0010 sample, 0100 settle, 1000 idle
i_prog_wr  in  1  push one program entry
i_prog_data  in  NIB_W+1  bit NIB_W = 1 command, 0 data; [NIB_W-1:0] nibble
o_prog_full  out  1  FIFO holds 2**PROG_AW entries
o_prog_level  out  PROG_AW+1  current FIFO occupancy
i_rd_start  in  1  load read burst length
i_rd_count  in  RD_CNT_W  number of nibbles to read
o_rd_valid  out  1  one-cycle strobe: o_rd_nibble valid
o_rd_nibble  out  NIB_W  captured bus nibble
o_bus_clk_en  out  1  bus cycle strobe
o_bus_is_data  out  1  1 = data nibble, 0 = command nibble
o_bus_nibble_out  out  NIB_W  nibble driven to bus
i_bus_nibble_in  in  NIB_W  nibble from bus
o_busy  out  1  FIFO non-empty, read pending, or bus cycle in flight
o_error  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: FIFO pointers 0, level 0, read counter 0, state IDLE. Outputs: o_bus_clk_en=0, o_bus_is_data=0, o_bus_nibble_out=0, o_rd_valid=0, o_rd_nibble=0, o_error=0, o_busy=0. Reset mid-burst or mid-cycle aborts the burst and discards all FIFO contents.
- Push: accepted when i_prog_wr=1, o_prog_full=0 and i_clk_en=1. Push is independent of phase. Full is evaluated before any pop in the same cycle, so a push while full is dropped even if a pop also occurs.
- States: IDLE, WRITE, READ.
- Phase 0001, priority rule: a non-empty FIFO wins over a pending read.
  - FIFO non-empty: pop head, drive o_bus_nibble_out = head[NIB_W-1:0] and o_bus_is_data = !head[NIB_W], set o_bus_clk_en=1, enter WRITE.
  - Else if read counter != 0: set o_bus_clk_en=1, enter READ.
  - Else: stay IDLE.
- Phase 0010: o_bus_clk_en returns to 0.
  - In READ: capture i_bus_nibble_in into o_rd_nibble, pulse o_rd_valid for exactly 1 i_clk, decrement the read counter.
  - Return to IDLE.
- Phases 0100 and 1000: no bus activity.
- o_busy is registered and updated in phase 0100: 1 if level != 0, read counter != 0, or state != IDLE; else 0.
- Read burst load: i_rd_start loads i_rd_count, overwriting any remaining count.
  - If i_rd_start coincides with a READ-phase 0010 decrement, the load wins.
  - i_rd_count=0 cancels a pending burst.
- Pointer wrap: read and write pointers wrap modulo 2**PROG_AW. Level is PROG_AW+1 bits so that full and empty are distinguishable.
- Bus cycle latency: an entry pushed while IDLE appears on the bus at the next phase 0001.
- A write that arrives mid-burst pre-empts the next read slot. The read counter is untouched and the burst resumes afterwards.

Optional Feature:
Macro SATURN_BUS_SEQ_CHECK_EN.
- Defined: o_error sets sticky (cleared only by reset) on any of:
  - push while full;
  - i_phases not one-hot while i_clk_en=1;
  - i_rd_start while state=READ.
  The sequencer keeps operating after an error.
- Undefined: o_error tied to 0 and no checker logic is built. Push while full is still silently dropped.

Test Plan:
- Reset, then push {1,0x3},{0,0xA},{0,0x5} and run phases -> three bus cycles in order: (is_data=0, 0x3), (1, 0xA), (1, 0x5), each with o_bus_clk_en high for exactly phase 0001; o_busy falls in the phase 0100 after the last.
- i_rd_start with count=4, bus returns 0x1,0x2,0x3,0x4 -> four o_rd_valid pulses carrying 0x1..0x4; o_busy=0 afterwards.
- Push 32 entries with PROG_AW=5 -> o_prog_full=1, o_prog_level=32; a 33rd push is dropped; with the macro defined, o_error=1; 32 bus cycles are emitted and the pointers wrap correctly on the refill.
- Read burst of 3 active; push one command 0x8 after the first read -> bus order: read, cmd 0x8, read, read.
- Assert reset during the phase 0010 of a read with 5 FIFO entries queued -> no o_rd_valid, level=0, all outputs at reset values on the next cycle.
- Hold i_clk_en=0 for 10 cycles mid-burst -> no state change and no strobes; the burst resumes exactly where it stopped.
